warp_fetch_sched: RTL and testbench
===================================

// Module: warp_fetch_sched
// PURPOSE
//  Parametrised multi-warp fetch front end, successor to the fixed 8-warp fetch/decode port list.
//  Holds one PC and one active bit per warp, round-robin picks one eligible warp per cycle,
//  reads the I-cache, and delivers a tagged instruction to decode.
//  Sits between the TM/SIMT/IB control inputs and the decoder, which drives the ID0/ID1 slots.
// PARAMETERS
//  NUM_WARPS  8                    warp count, power of 2, >=2
//  WID_W      $clog2(NUM_WARPS)    warp-ID width
//  PC_W       10                   PC width; word address
//  INST_W     32                   instruction width
// PORTS
//  clk                     in   1            clock
//  rst_n                   in   1            async active-low reset
//  WarpID_TM_PC            in   WID_W        warp being launched
//  UpdatePC_TM_PC          in   1            launch strobe
//  StartingPC_TM_PC        in   PC_W         launch PC
//  UpdatePC_Qual1_SIMT_PC  in   NUM_WARPS    ALU branch redirect, per warp
//  TargetAddr_ALU_PC       in   NUM_WARPS*PC_W  flattened targets; warp w at [w*PC_W +: PC_W]
//  UpdatePC_Qual2_SIMT_PC  in   NUM_WARPS    SIMT reconvergence redirect
//  TargetAddr_SIMT_PC      in   NUM_WARPS*PC_W  flattened, same layout
//  Stall_SIMT_PC           in   NUM_WARPS    warp must not fetch
//  Req_IB_PC               in   NUM_WARPS    IB has space for warp
//  Exit_ID_PC              in   NUM_WARPS    warp decoded EXIT; deactivate
//  Addr_PC_ICache          out  PC_W         I-cache read address
//  RdEn_PC_ICache          out  1            I-cache read enable
//  Inst_ICache_IF          in   INST_W       read data, valid 1 cycle after RdEn
//  Valid_IF_ID             out  NUM_WARPS    one-hot: instruction valid for warp
//  WarpID_IF_ID            out  WID_W        warp of delivered instruction
//  Inst_IF_ID              out  INST_W       delivered instruction
//  PCplus4_IF_ID           out  PC_W         fetch PC + 1 (return address for CALL)
//  Active_PC               out  NUM_WARPS    per-warp active bits
// BEHAVIOUR
//  Reset: all PCs 0, Active 0, RR pointer 0, RdEn 0, Addr 0, Valid 0, WarpID/Inst/PCplus4 0.
//  Per-warp next-PC priority, highest first:
//   TM launch (sets Active) > Qual1 (ALU target) > Qual2 (SIMT target) > fetch increment.
//  Exit_ID_PC[w] clears Active[w]. A TM launch of w in the same cycle wins: Active stays 1.
//  Eligible[w] = Active & Req_IB & ~Stall & ~Qual1 & ~Qual2 & ~Exit & ~(TM launch of w), all this cycle.
//  Arbiter: first eligible warp scanning up from the RR pointer, wrapping at NUM_WARPS-1 -> 0.
//   On grant g: pointer <= (g+1) mod NUM_WARPS. With no grant, the pointer holds.
//  Cycle t (grant g), all combinational:
//   Addr = PC[g], RdEn = 1.
//   PC[g] <= PC[g]+1, wrapping modulo 2^PC_W.
//   g and PC[g]+1 are registered as the in-flight tag.
//   With no grant: RdEn = 0 and Addr = 0.
//  Cycle t+1: Inst_ICache_IF is captured.
//  Cycle t+2: registered outputs present the result:
//   Valid_IF_ID = onehot(g), WarpID_IF_ID = g, Inst_IF_ID = captured data, PCplus4_IF_ID = tag PC.
//   Fetch-to-output latency is 2 cycles.
//   Throughput: 1 instruction/cycle, and the same warp may win back-to-back.
//  Squash: in-flight fetch of warp g is killed (no Valid at t+2) if any of
//   TM launch, Qual1, Qual2 or Exit for g occurs in cycle t+1.
//  Valid_IF_ID is a 1-cycle pulse. Decode has no backpressure; IB throttles only through Req_IB_PC.
//  A reset assertion mid-fetch drops all in-flight state. No output pulses after reset releases.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   adds outputs FetchCnt_PC[31:0] (valid deliveries) and SquashCnt_PC[31:0] (killed fetches).
//   Both reset to 0 and saturate at 32'hFFFF_FFFF.
//  FETCH_PERF_CNT_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//  Launch w3 @PC 0x040, Req[3]=1 -> Addr 0x040,0x041,0x042 on consecutive cycles;
//   Valid_IF_ID=8'h08 2 cycles later; PCplus4 = 0x041,0x042,...
//  Launch w0..w7 @0x100+w, all Req=1 -> grants 0,1,...,7,0 round-robin; each PC increments once per grant.
//  Fetch w2 @0x010 in cycle t, Qual1[2] with target 0x200 in t+1 -> no Valid for that fetch;
//   next w2 Addr = 0x200.
//  Same cycle Qual1[5]=0x080 and Qual2[5]=0x090 -> PC[5]=0x080.
//   Same cycle TM launch w5 @0x000 plus Qual1[5] -> PC[5]=0x000.
//  PC[1]=0x3FF (PC_W=10) fetched -> PC[1] wraps to 0x000 and PCplus4_IF_ID = 0x000.
//   Stall_SIMT_PC[1]=1 -> w1 never granted; the RR pointer skips it.
//  Exit_ID_PC[4] -> Active[4]=0, no further w4 fetches.
//   Assert rst_n=0 with a fetch in flight -> all outputs 0 next edge, no stray Valid after release.

Source files
------------

// File: rtl/warp_fetch_sched.sv
// Multi-warp fetch front end: per-warp PC/active state, round-robin pick, 2-cycle I-cache path.
// Optional perf counters (FetchCnt_PC, SquashCnt_PC) when FETCH_PERF_CNT_EN is defined.
module warp_fetch_sched #(
    parameter int NUM_WARPS = 8,
    parameter int WID_W     = $clog2(NUM_WARPS),
    parameter int PC_W      = 10,
    parameter int INST_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WID_W-1:0]          WarpID_TM_PC,
    input  logic                      UpdatePC_TM_PC,
    input  logic [PC_W-1:0]           StartingPC_TM_PC,
    input  logic [NUM_WARPS-1:0]      UpdatePC_Qual1_SIMT_PC,
    input  logic [NUM_WARPS*PC_W-1:0] TargetAddr_ALU_PC,
    input  logic [NUM_WARPS-1:0]      UpdatePC_Qual2_SIMT_PC,
    input  logic [NUM_WARPS*PC_W-1:0] TargetAddr_SIMT_PC,
    input  logic [NUM_WARPS-1:0]      Stall_SIMT_PC,
    input  logic [NUM_WARPS-1:0]      Req_IB_PC,
    input  logic [NUM_WARPS-1:0]      Exit_ID_PC,
    output logic [PC_W-1:0]           Addr_PC_ICache,
    output logic                      RdEn_PC_ICache,
    input  logic [INST_W-1:0]         Inst_ICache_IF,
    output logic [NUM_WARPS-1:0]      Valid_IF_ID,
    output logic [WID_W-1:0]          WarpID_IF_ID,
    output logic [INST_W-1:0]         Inst_IF_ID,
    output logic [PC_W-1:0]           PCplus4_IF_ID,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]               FetchCnt_PC,
    output logic [31:0]               SquashCnt_PC,
`endif
    output logic [NUM_WARPS-1:0]      Active_PC
);

    logic [PC_W-1:0]      pc_q [NUM_WARPS];
    logic [NUM_WARPS-1:0] active_q;
    logic [WID_W-1:0]     ptr_q;

    logic [NUM_WARPS-1:0] tm_hit;
    logic [NUM_WARPS-1:0] kill;
    logic [NUM_WARPS-1:0] elig;
    logic                 gnt_vld;
    logic [WID_W-1:0]     gnt_id;

    logic                 s1_vld;
    logic [WID_W-1:0]     s1_wid;
    logic [PC_W-1:0]      s1_pc;
    logic                 deliver;

    assign tm_hit = UpdatePC_TM_PC ? (NUM_WARPS'(1) << WarpID_TM_PC) : '0;
    assign kill   = tm_hit | UpdatePC_Qual1_SIMT_PC
                  | UpdatePC_Qual2_SIMT_PC | Exit_ID_PC;
    assign elig   = active_q & Req_IB_PC & ~Stall_SIMT_PC & ~kill;

    // Scan upward from the RR pointer; WID_W arithmetic wraps for free.
    always_comb begin
        logic [WID_W-1:0] idx;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = ptr_q + WID_W'(i);
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign RdEn_PC_ICache = gnt_vld;
    assign Addr_PC_ICache = gnt_vld ? pc_q[gnt_id] : '0;
    assign Active_PC      = active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= '0;
            end
            active_q <= '0;
            ptr_q    <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (tm_hit[w]) begin
                    pc_q[w] <= StartingPC_TM_PC;
                end else if (UpdatePC_Qual1_SIMT_PC[w]) begin
                    pc_q[w] <= TargetAddr_ALU_PC[w*PC_W +: PC_W];
                end else if (UpdatePC_Qual2_SIMT_PC[w]) begin
                    pc_q[w] <= TargetAddr_SIMT_PC[w*PC_W +: PC_W];
                end else if (gnt_vld && gnt_id == WID_W'(w)) begin
                    pc_q[w] <= pc_q[w] + 1'b1;
                end
                if (tm_hit[w]) begin
                    active_q[w] <= 1'b1;
                end else if (Exit_ID_PC[w]) begin
                    active_q[w] <= 1'b0;
                end
            end
            if (gnt_vld) begin
                ptr_q <= gnt_id + 1'b1;
            end
        end
    end

    // In-flight tag for the fetch issued this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_wid <= '0;
            s1_pc  <= '0;
        end else begin
            s1_vld <= gnt_vld;
            if (gnt_vld) begin
                s1_wid <= gnt_id;
                s1_pc  <= pc_q[gnt_id] + 1'b1;
            end
        end
    end

    assign deliver = s1_vld && !kill[s1_wid];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Valid_IF_ID   <= '0;
            WarpID_IF_ID  <= '0;
            Inst_IF_ID    <= '0;
            PCplus4_IF_ID <= '0;
        end else begin
            Valid_IF_ID <= deliver ? (NUM_WARPS'(1) << s1_wid) : '0;
            if (deliver) begin
                WarpID_IF_ID  <= s1_wid;
                Inst_IF_ID    <= Inst_ICache_IF;
                PCplus4_IF_ID <= s1_pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FetchCnt_PC  <= '0;
            SquashCnt_PC <= '0;
        end else begin
            if (deliver && FetchCnt_PC != 32'hFFFF_FFFF) begin
                FetchCnt_PC <= FetchCnt_PC + 1'b1;
            end
            if (s1_vld && kill[s1_wid] && SquashCnt_PC != 32'hFFFF_FFFF) begin
                SquashCnt_PC <= SquashCnt_PC + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_warp_fetch_sched.sv
// Directed bench for warp_fetch_sched: launch, round-robin, squash,
// priority, wrap, stall, exit and mid-fetch reset.
module tb_warp_fetch_sched;

    localparam int NW = 8;
    localparam int WW = 3;
    localparam int PW = 10;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] tm_wid;
    logic          tm_upd;
    logic [PW-1:0] tm_pc;
    logic [NW-1:0] q1;
    logic [NW*PW-1:0] tgt1;
    logic [NW-1:0] q2;
    logic [NW*PW-1:0] tgt2;
    logic [NW-1:0] stall;
    logic [NW-1:0] req;
    logic [NW-1:0] ext;
    logic [PW-1:0] addr;
    logic          rden;
    logic [IW-1:0] inst_ic;
    logic [NW-1:0] valid;
    logic [WW-1:0] wid_o;
    logic [IW-1:0] inst_o;
    logic [PW-1:0] pcp4;
    logic [NW-1:0] active;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    always #5 clk = ~clk;

    warp_fetch_sched dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .WarpID_TM_PC           (tm_wid),
        .UpdatePC_TM_PC         (tm_upd),
        .StartingPC_TM_PC       (tm_pc),
        .UpdatePC_Qual1_SIMT_PC (q1),
        .TargetAddr_ALU_PC      (tgt1),
        .UpdatePC_Qual2_SIMT_PC (q2),
        .TargetAddr_SIMT_PC     (tgt2),
        .Stall_SIMT_PC          (stall),
        .Req_IB_PC              (req),
        .Exit_ID_PC             (ext),
        .Addr_PC_ICache         (addr),
        .RdEn_PC_ICache         (rden),
        .Inst_ICache_IF         (inst_ic),
        .Valid_IF_ID            (valid),
        .WarpID_IF_ID           (wid_o),
        .Inst_IF_ID             (inst_o),
        .PCplus4_IF_ID          (pcp4),
        .Active_PC              (active)
    );

    // I-cache model: data tagged with its address, one cycle after RdEn.
    logic [IW-1:0] ic_q = '0;
    always_ff @(posedge clk) begin
        if (rden) ic_q <= 32'hC0DE_0000 | 32'(addr);
    end
    assign inst_ic = ic_q;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        tm_upd = 1'b0; q1 = '0; q2 = '0;
        stall = '0; req = '0; ext = '0;
    endtask

    task automatic launch(input int w, input logic [PW-1:0] pc);
        tm_upd = 1'b1;
        tm_wid = WW'(w);
        tm_pc  = pc;
    endtask

    task automatic do_reset();
        cyc(); idle(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; tm_wid = '0; tm_pc = '0;
        tgt1 = '0; tgt2 = '0;
        idle();
        #1;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_rden", 32'(rden), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_pcp4", 32'(pcp4), 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        cyc(); cyc(); rst_n = 1'b1;

        // Single-warp launch and streaming
        cyc(); launch(3, 10'h040); req = 8'h08;
        #1 chk("t1_noeligible", 32'(rden), 32'h0);
        cyc(); tm_upd = 1'b0;
        #1 chk("t1_addr0", 32'(addr), 32'h040);
        chk("t1_rden", 32'(rden), 32'h1);
        chk("t1_active", 32'(active), 32'h08);
        cyc();
        #1 chk("t1_addr1", 32'(addr), 32'h041);
        chk("t1_novalid_yet", 32'(valid), 32'h0);
        cyc();
        #1 chk("t1_addr2", 32'(addr), 32'h042);
        chk("t1_valid0", 32'(valid), 32'h08);
        chk("t1_wid0", 32'(wid_o), 32'h3);
        chk("t1_pcp4_0", 32'(pcp4), 32'h041);
        chk("t1_inst0", inst_o, 32'hC0DE_0040);
        cyc(); req = '0;
        #1 chk("t1_valid1", 32'(valid), 32'h08);
        chk("t1_pcp4_1", 32'(pcp4), 32'h042);
        chk("t1_inst1", inst_o, 32'hC0DE_0041);
        cyc();
        #1 chk("t1_pcp4_2", 32'(pcp4), 32'h043);
        cyc();
        #1 chk("t1_pulse_end", 32'(valid), 32'h0);

        // Round robin across all warps
        do_reset();
        for (int w = 0; w < NW; w++) begin
            cyc(); launch(w, 10'(32'h100 + w));
        end
        cyc(); tm_upd = 1'b0; req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            #1;
            chk($sformatf("rr_addr%0d", k), 32'(addr),
                32'h100 + (k % 8) + (k / 8));
            if (k >= 2) begin
                chk($sformatf("rr_valid%0d", k), 32'(valid),
                    32'h1 << (k - 2));
                chk($sformatf("rr_pcp4_%0d", k), 32'(pcp4),
                    32'h100 + (k - 2) + 1);
            end
            cyc();
        end
        req = '0;
        #1 chk("rr_active", 32'(active), 32'hFF);

        // Squash by Qual1 in the cycle after fetch
        do_reset();
        cyc(); launch(2, 10'h010);
        cyc(); tm_upd = 1'b0; req = 8'h04;
        #1 chk("sq_addr", 32'(addr), 32'h010);
        cyc(); req = '0; q1 = 8'h04; tgt1[2*PW +: PW] = 10'h200;
        #1 chk("sq_q1_inelig", 32'(rden), 32'h0);
        cyc(); q1 = '0; req = 8'h04;
        #1 chk("sq_killed", 32'(valid), 32'h0);
        chk("sq_redirect", 32'(addr), 32'h200);
        cyc(); req = '0;
        #1 chk("sq_gap", 32'(valid), 32'h0);
        cyc(); launch(5, 10'h000);
        #1 chk("sq_valid", 32'(valid), 32'h04);
        chk("sq_pcp4", 32'(pcp4), 32'h201);

        // Next-PC priority
        cyc(); tm_upd = 1'b0; q1 = 8'h20; q2 = 8'h20;
        tgt1[5*PW +: PW] = 10'h080; tgt2[5*PW +: PW] = 10'h090;
        cyc(); q1 = '0; q2 = '0; req = 8'h20;
        #1 chk("pri_q1_over_q2", 32'(addr), 32'h080);
        cyc(); req = '0; launch(5, 10'h000); q1 = 8'h20;
        cyc(); tm_upd = 1'b0; q1 = '0; req = 8'h20;
        #1 chk("pri_tm_over_q1", 32'(addr), 32'h000);

        // PC wrap, then stall skipping
        do_reset();
        cyc(); launch(1, 10'h3FF);
        cyc(); tm_upd = 1'b0; req = 8'h02;
        #1 chk("wr_addr", 32'(addr), 32'h3FF);
        cyc(); req = '0;
        cyc(); req = 8'h02;
        #1 chk("wr_valid", 32'(valid), 32'h02);
        chk("wr_pcp4", 32'(pcp4), 32'h000);
        chk("wr_addr_next", 32'(addr), 32'h000);
        cyc(); req = '0; launch(0, 10'h000);
        cyc(); launch(2, 10'h020);
        cyc(); tm_upd = 1'b0; stall = 8'h02; req = 8'h07;
        #1 chk("st_g2a", 32'(addr), 32'h020);
        cyc();
        #1 chk("st_g0a", 32'(addr), 32'h000);
        cyc();
        #1 chk("st_g2b", 32'(addr), 32'h021);
        cyc();
        #1 chk("st_g0b", 32'(addr), 32'h001);

        // Exit deactivates and squashes
        cyc(); stall = '0; req = '0; launch(4, 10'h050);
        cyc(); tm_upd = 1'b0; req = 8'h10;
        #1 chk("ex_addr", 32'(addr), 32'h050);
        cyc(); ext = 8'h10;
        #1 chk("ex_inelig", 32'(rden), 32'h0);
        cyc(); ext = '0;
        #1 chk("ex_active", 32'(active), 32'h07);
        chk("ex_nofetch", 32'(rden), 32'h0);
        chk("ex_squash", 32'(valid), 32'h0);

        // Reset with a fetch in flight
        cyc(); req = 8'h01;
        #1 chk("mr_rden", 32'(rden), 32'h1);
        chk("mr_addr", 32'(addr), 32'h002);
        cyc(); rst_n = 1'b0;
        #1 chk("mr_valid", 32'(valid), 32'h0);
        chk("mr_rden0", 32'(rden), 32'h0);
        chk("mr_active", 32'(active), 32'h0);
        chk("mr_pcp4", 32'(pcp4), 32'h0);
        cyc(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1 chk($sformatf("mr_stray%0d", k), 32'(valid), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
